// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MATCH = 2'd2
    } state_t;

    localparam int PATTERN_LEN_MIN = 2;
    localparam int PATTERN_LEN_MAX = 16;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky flag raised when it reaches all-ones.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            // clear wins over a coincident increment
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
            if (count == CNT_MAX - 1'b1) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a programmable PATTERN_LEN-bit serial pattern with
// optional overlap, a one-cycle match pulse and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1100,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             din,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat,
    output logic             filled
);

    localparam int                FILL_W    = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_LEN - 1);

    generate
        if (PATTERN_LEN < PATTERN_LEN_MIN || PATTERN_LEN > PATTERN_LEN_MAX) begin : g_bad_len
            $error("seq_detector_param: PATTERN_LEN out of range");
        end
    endgenerate

    logic [PATTERN_LEN-1:0] win;
    logic [PATTERN_LEN-1:0] nwin;
    logic [FILL_W-1:0]      fill;
    logic                   hit;
    state_t                 state;

    // Oldest bit falls off the top; the new bit enters at the LSB.
    assign nwin   = PATTERN_LEN'({win, din});
    assign hit    = en && (nwin == PATTERN) && (fill >= FILL_LAST);
    assign filled = (fill == FILL_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win   <= '0;
            fill  <= '0;
            state <= ST_FILL;
            z     <= 1'b0;
        end else begin
            if (en) begin
                win <= nwin;
                // Non-overlapping mode masks stale window bits by restarting fill.
                if (hit && !OVERLAP) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end

            z <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (hit) begin
                        state <= ST_MATCH;
                        z     <= 1'b1;
                    end else if (en && (fill == FILL_LAST)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        state <= ST_MATCH;
                        z     <= 1'b1;
                    end
                end
                ST_MATCH: begin
                    if (hit) begin
                        state <= ST_MATCH;
                        z     <= 1'b1;
                    end else if (OVERLAP) begin
                        state <= ST_RUN;
                    end else begin
                        state <= ST_FILL;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_match_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (hit),
        .clear  (clear),
        .count  (match_cnt),
        .sat    (sat)
    );

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector. Successor to the team's fixed 4-bit "1100" detector.
- Samples a 1-bit stream on qualified clock edges and compares the last PATTERN_LEN bits against a programmable PATTERN. Overlapping or non-overlapping detection is selectable.
- Drives a one-cycle Moore pulse per match and keeps a saturating match counter.
- Sits between the button debouncer/synchroniser and the display/LED logic on the lab board.

Parameters:
- PATTERN_LEN, 4, pattern length N in bits; legal range 2..16.
- PATTERN, 4'b1100, target sequence; MSB is the first (oldest) bit received. Width is PATTERN_LEN.
- OVERLAP, 1, 1 = overlapping (window retained after a match); 0 = non-overlapping (window restarts after a match).
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; din is shifted in only on edges where en=1.
- din  in  1  serial data bit (already synchronised/debounced).
- clear  in  1  synchronous clear of match_cnt and sat.
- z  out  1  Moore match pulse; high exactly while state = ST_MATCH.
- match_cnt  out  CNT_W  number of matches since reset/clear; saturating.
- sat  out  1  sticky; set when match_cnt reaches all-ones.
- filled  out  1  high when fill = N, i.e. the window holds N valid bits.

Behaviour:
- One clock; reset is asynchronous and active-low. reset_n=0 forces immediately: win=0, fill=0, state=ST_FILL, z=0, match_cnt=0, sat=0, filled=0. This holds mid-sequence; partial progress is discarded.
- Datapath registers:
  - win[N-1:0]: shift register. On an en edge, win <= {win[N-2:0], din}.
  - fill: 0..N, saturating at N, incremented on each en edge.
- nwin = {win[N-2:0], din}. hit = en & (nwin == PATTERN) & (fill >= N-1).
- States (Moore, z decoded from state only):
  - ST_FILL: fill < N. On hit -> ST_MATCH. Else if the en edge makes fill = N -> ST_RUN. Else stay.
  - ST_RUN: window full, no match. On hit -> ST_MATCH. Else stay.
  - ST_MATCH: z=1. Exit on the next clock regardless of en. If hit on that edge (possible only when OVERLAP=1), stay in ST_MATCH, so z stays high for consecutive matches. Otherwise -> ST_RUN (OVERLAP=1) or ST_FILL (OVERLAP=0).
- OVERLAP=0: on the hit edge fill <= 0 (win may keep stale bits; it is masked by fill). The next match needs N fresh bits.
- OVERLAP=1: fill stays N after a hit.
- Latency: z rises one clk after the edge that samples the final pattern bit.
- en=0: win, fill and state hold, except that ST_MATCH still exits after one cycle.
- match_cnt:
  - +1 on each hit edge.
  - Saturates at 2^CNT_W-1; at saturation, sat <= 1.
  - clear has priority over a simultaneous hit: count=0, sat=0.
  - clear does not affect win, fill or state.
- filled = (fill == N), registered-equivalent (decoded from the fill register).
- A pattern of all ones or all zeros is legal. Self-overlap is handled naturally by the shift-register comparison; no failure table is required.

Decomposition:
- Package seq_det_pkg holds:
  - state encoding constants ST_FILL=2'd0, ST_RUN=2'd1, ST_MATCH=2'd2 (2'd3 is illegal and recovers to ST_FILL);
  - the legal-range constants PATTERN_LEN_MIN=2 and PATTERN_LEN_MAX=16.
- One sub-module: seq_match_counter, the saturating CNT_W counter with inc, clear and sat.
- Shift register, fill counter and FSM stay in the top module.

Test Plan:
- Reset/default (N=4, 1100, OVERLAP=1): drive reset_n low mid-stream after din=1,1 -> z=0, match_cnt=0, filled=0 immediately. After release, 1,1,0,0 -> z high for exactly 1 cycle, one clk after the 4th edge; match_cnt=1.
- Overlap: PATTERN=3'b101, OVERLAP=1, stream 1,0,1,0,1 -> 2 z pulses (after bits 3 and 5), match_cnt=2. Same stream with OVERLAP=0 -> 1 pulse, match_cnt=1.
- Consecutive matches: PATTERN=2'b11, OVERLAP=1, din=1 for 5 en edges -> z high for 4 consecutive cycles starting after edge 2; match_cnt=4.
- en gating: 1100 with en=0 for 3 cycles between bits 2 and 3 -> still exactly one z pulse, after the 4th enabled edge. Bits presented while en=0 are ignored.
- Saturation: CNT_W=2, 4 matches -> match_cnt=3 and sat=1 after the 3rd match, stays 3 after the 4th. clear pulsed in the same cycle as a hit -> match_cnt=0, sat=0.
- Width sweep: N=16, PATTERN=16'hA5C3 -> no z before 16 edges. Exact pattern -> one pulse. Pattern with a single bit flipped -> no pulse.
